// File: rtl/hls_deadlock_persist_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : hls_deadlock_persist_monitor
//  Purpose  : Per-process deadlock monitor for the HLS dataflow deadlock
//             detection network. A masked block indication must persist for
//             THRESHOLD consecutive cycles before it is declared a deadlock.
//             The deadlock flag is sticky and carries a snapshot of the
//             blocking cause. Software can clear it. A saturating counter
//             records how many detection events occurred.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock            in   rising-edge clock
//    reset_n          in   asynchronous active-low reset
//    axis_block_sigs  in   per-stream blocked indications   [NUM_AXIS]
//    inst_block_sigs  in   per-instance blocked indications [NUM_BLK]
//    inst_idle_sigs   in   per-instance idle indications    [NUM_IDLE]
//    enable           in   monitoring enable (level)
//    clear            in   synchronous clear of sticky state (pulse)
//    block            out  registered instantaneous block candidate
//    deadlock         out  sticky persistent-deadlock flag
//    cause_axis       out  masked axis blocks captured on detection
//    cause_blk        out  masked instance blocks captured on detection
//    detect_count     out  saturating count of detection events [EVT_W]
// ============================================================================
module hls_deadlock_persist_monitor #(
  parameter int                  NUM_AXIS  = 5,
  parameter int                  NUM_BLK   = 5,
  parameter int                  NUM_IDLE  = 14,
  parameter logic [NUM_AXIS-1:0] AXIS_MASK = 5'b01100,
  parameter logic [NUM_BLK-1:0]  BLK_MASK  = '0,
  parameter logic [NUM_IDLE-1:0] IDLE_MASK = '0,
  parameter int                  THRESHOLD = 16,
  parameter int                  EVT_W     = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_BLK-1:0]  inst_block_sigs,
  input  logic [NUM_IDLE-1:0] inst_idle_sigs,
  input  logic                enable,
  input  logic                clear,
  output logic                block,
  output logic                deadlock,
  output logic [NUM_AXIS-1:0] cause_axis,
  output logic [NUM_BLK-1:0]  cause_blk,
  output logic [EVT_W-1:0]    detect_count
);

  localparam int               CNT_W    = $clog2(THRESHOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_DETECTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enter_det;
  logic              idle_all;
  logic              candidate;
  logic [NUM_AXIS-1:0] masked_axis;
  logic [NUM_BLK-1:0]  masked_blk;

  // An all-zero idle mask disables suppression entirely, otherwise the
  // reduction over an empty selection would always read as "all idle".
  assign idle_all    = (IDLE_MASK != '0) && ((inst_idle_sigs & IDLE_MASK) == IDLE_MASK);
  assign masked_axis = axis_block_sigs & AXIS_MASK;
  assign masked_blk  = inst_block_sigs & BLK_MASK;
  assign candidate   = enable & ~idle_all & ((|masked_axis) | (|masked_blk));

  assign deadlock = (state_q == ST_DETECTED);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_det = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          cnt_d = '0;
        end else if (candidate) begin
          if (THRESHOLD == 1) begin
            state_d   = ST_DETECTED;
            enter_det = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_PENDING: begin
        if (clear || !candidate) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_DETECTED;
          enter_det = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DETECTED: begin
        // Sticky: only clear releases it, enable/candidate are ignored.
        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      block        <= 1'b0;
      cause_axis   <= '0;
      cause_blk    <= '0;
      detect_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block   <= candidate;
      // Cause is zero whenever the flag is low, captured on entry, held after.
      if (state_d != ST_DETECTED) begin
        cause_axis <= '0;
        cause_blk  <= '0;
      end else if (enter_det) begin
        cause_axis <= masked_axis;
        cause_blk  <= masked_blk;
      end
      if (enter_det && (detect_count != {EVT_W{1'b1}})) begin
        detect_count <= detect_count + EVT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hls_deadlock_persist_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hls_deadlock_persist_monitor
//  Purpose  : Self-checking bench for hls_deadlock_persist_monitor. Three
//             instances with different parameter sets share one stimulus:
//               k=0 : defaults (THRESHOLD 16, no idle suppression)
//               k=1 : BLK_MASK 00011, IDLE_MASK 3FFF, EVT_W 2
//               k=2 : THRESHOLD 1, BLK_MASK 10000
//             A run-length reference model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hls_deadlock_persist_monitor;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  axis_block_sigs = '0;
  logic [4:0]  inst_block_sigs = '0;
  logic [13:0] inst_idle_sigs = '0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  logic       block0, block1, block2, dl0, dl1, dl2;
  logic [4:0] ca0, ca1, ca2, cb0, cb1, cb2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;

  hls_deadlock_persist_monitor u_k0 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .enable(enable), .clear(clear), .block(block0), .deadlock(dl0),
    .cause_axis(ca0), .cause_blk(cb0), .detect_count(cnt0));

  hls_deadlock_persist_monitor #(
    .BLK_MASK(5'b00011), .IDLE_MASK(14'h3FFF), .EVT_W(2)
  ) u_k1 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .enable(enable), .clear(clear), .block(block1), .deadlock(dl1),
    .cause_axis(ca1), .cause_blk(cb1), .detect_count(cnt1));

  hls_deadlock_persist_monitor #(
    .BLK_MASK(5'b10000), .THRESHOLD(1)
  ) u_k2 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .enable(enable), .clear(clear), .block(block2), .deadlock(dl2),
    .cause_axis(ca2), .cause_blk(cb2), .detect_count(cnt2));

  logic       d_block [3];
  logic       d_dl    [3];
  logic [4:0] d_ca    [3];
  logic [4:0] d_cb    [3];
  logic [7:0] d_cnt   [3];
  assign d_block[0] = block0; assign d_block[1] = block1; assign d_block[2] = block2;
  assign d_dl[0]    = dl0;    assign d_dl[1]    = dl1;    assign d_dl[2]    = dl2;
  assign d_ca[0]    = ca0;    assign d_ca[1]    = ca1;    assign d_ca[2]    = ca2;
  assign d_cb[0]    = cb0;    assign d_cb[1]    = cb1;    assign d_cb[2]    = cb2;
  assign d_cnt[0]   = cnt0;   assign d_cnt[1]   = {6'b0, cnt1}; assign d_cnt[2] = cnt2;

  // Per-instance configuration as seen by the reference model.
  int          p_th   [3];
  logic [4:0]  p_am   [3];
  logic [4:0]  p_bm   [3];
  logic [13:0] p_im   [3];
  int          p_emax [3];

  // Reference model: length of the current run of candidate cycles plus the
  // sticky flag, snapshot and event count.
  logic       m_block [3];
  logic       m_dl    [3];
  logic [4:0] m_ca    [3];
  logic [4:0] m_cb    [3];
  int         m_cnt   [3];
  int         m_run   [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_block[k] = 1'b0; m_dl[k] = 1'b0; m_ca[k] = '0; m_cb[k] = '0;
      m_cnt[k] = 0; m_run[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit idle_all, cand;
      idle_all = (p_im[k] != 0) && ((inst_idle_sigs & p_im[k]) == p_im[k]);
      cand = enable && !idle_all &&
             (((axis_block_sigs & p_am[k]) != 0) || ((inst_block_sigs & p_bm[k]) != 0));
      m_block[k] = cand;
      if (clear) begin
        m_dl[k] = 1'b0; m_ca[k] = '0; m_cb[k] = '0; m_run[k] = 0;
      end else if (m_dl[k]) begin
        // sticky
      end else if (cand) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] >= p_th[k]) begin
          m_dl[k] = 1'b1;
          m_ca[k] = axis_block_sigs & p_am[k];
          m_cb[k] = inst_block_sigs & p_bm[k];
          if (m_cnt[k] < p_emax[k]) m_cnt[k] = m_cnt[k] + 1;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  // Advance one clock and leave the bench 1 time unit past the edge.
  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic pulse_clear();
    axis_block_sigs = '0;
    inst_block_sigs = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({d_block[k], d_dl[k], d_ca[k], d_cb[k], d_cnt[k]} !== 20'd0) begin
        errors++;
        $display("FAIL reset k%0d got blk=%b dl=%b ca=%b cb=%b cnt=%0d expected all zero",
                 k, d_block[k], d_dl[k], d_ca[k], d_cb[k], d_cnt[k]);
      end
    end
  endtask

  task automatic test_basic_window();
    enable = 1'b1;
    inst_idle_sigs = '0;
    repeat (10) tick();
    axis_block_sigs = 5'b00100;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (block0 !== 1'b1) begin
        errors++; $display("FAIL basic_block0 tick %0d got %b expected 1", i, block0);
      end
      checks++;
      if (dl0 !== (i >= 16)) begin
        errors++; $display("FAIL basic_dl0 tick %0d got %b expected %b", i, dl0, i >= 16);
      end
      checks++;
      if (dl2 !== 1'b1 || block2 !== 1'b1) begin
        errors++; $display("FAIL th1_dl_blk tick %0d got dl=%b blk=%b expected 1 1", i, dl2, block2);
      end
      if (i == 16) begin
        checks++;
        if (ca0 !== 5'b00100 || cnt0 !== 8'd1) begin
          errors++; $display("FAIL basic_cause got ca=%b cnt=%0d expected 00100 1", ca0, cnt0);
        end
      end
    end
  endtask

  task automatic test_restart();
    pulse_clear();
    tick();
    checks++;
    if (dl0 !== 1'b0 || ca0 !== 5'b0) begin
      errors++; $display("FAIL restart_clear got dl=%b ca=%b expected 0 00000", dl0, ca0);
    end
    axis_block_sigs = 5'b00100;
    repeat (10) tick();
    axis_block_sigs = 5'b00000;
    tick();
    axis_block_sigs = 5'b00100;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (dl0 !== (i >= 16)) begin
        errors++; $display("FAIL restart_dl0 tick %0d got %b expected %b", i, dl0, i >= 16);
      end
    end
    checks++;
    if (cnt0 !== 8'(m_cnt[0])) begin
      errors++; $display("FAIL restart_cnt got %0d expected %0d", cnt0, m_cnt[0]);
    end
  endtask

  task automatic test_unmasked();
    pulse_clear();
    axis_block_sigs = 5'b10011;
    for (int i = 0; i < 100; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_block[k] !== 1'b0 || d_dl[k] !== 1'b0) begin
          errors++;
          $display("FAIL unmasked k%0d tick %0d got blk=%b dl=%b expected 0 0", k, i, d_block[k], d_dl[k]);
        end
      end
    end
  endtask

  task automatic test_idle();
    pulse_clear();
    inst_idle_sigs = 14'h3FFF;
    axis_block_sigs = 5'b00100;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (block1 !== 1'b0 || dl1 !== 1'b0) begin
        errors++; $display("FAIL idle_supp tick %0d got blk=%b dl=%b expected 0 0", i, block1, dl1);
      end
    end
    inst_idle_sigs = 14'h3FFE;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (dl1 !== (i >= 16)) begin
        errors++; $display("FAIL idle_release tick %0d got %b expected %b", i, dl1, i >= 16);
      end
    end
  endtask

  task automatic test_enable_clear();
    int before0, before2;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dl0 !== 1'b1 || dl1 !== 1'b1 || block0 !== 1'b0) begin
        errors++; $display("FAIL enable_off tick %0d got dl0=%b dl1=%b blk0=%b expected 1 1 0", i, dl0, dl1, block0);
      end
    end
    before0 = m_cnt[0];
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (dl0 !== 1'b0 || ca0 !== 5'b0 || cnt0 !== 8'(before0)) begin
      errors++; $display("FAIL clear got dl=%b ca=%b cnt=%0d expected 0 00000 %0d", dl0, ca0, cnt0, before0);
    end
    // Clear wins over a same-cycle detection entry.
    before2 = m_cnt[2];
    enable = 1'b1;
    inst_idle_sigs = '0;
    axis_block_sigs = 5'b00100;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (dl2 !== 1'b0 || cnt2 !== 8'(before2) || block2 !== 1'b1) begin
      errors++; $display("FAIL clear_prio got dl=%b cnt=%0d blk=%b expected 0 %0d 1", dl2, cnt2, block2, before2);
    end
  endtask

  task automatic test_saturation();
    enable = 1'b1;
    inst_idle_sigs = '0;
    for (int n = 0; n < 5; n++) begin
      pulse_clear();
      axis_block_sigs = 5'b00100;
      repeat (16) tick();
      checks++;
      if (dl1 !== 1'b1) begin
        errors++; $display("FAIL sat_detect %0d got %b expected 1", n, dl1);
      end
    end
    checks++;
    if (cnt1 !== 2'd3) begin
      errors++; $display("FAIL saturation got %0d expected 3", cnt1);
    end
  endtask

  task automatic test_async_reset();
    for (int phase = 0; phase < 2; phase++) begin
      pulse_clear();
      axis_block_sigs = 5'b00100;
      repeat (phase == 0 ? 5 : 17) tick();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({d_block[k], d_dl[k], d_ca[k], d_cb[k], d_cnt[k]} !== 20'd0) begin
          errors++;
          $display("FAIL async_reset phase%0d k%0d got blk=%b dl=%b ca=%b cb=%b cnt=%0d expected all zero",
                   phase, k, d_block[k], d_dl[k], d_ca[k], d_cb[k], d_cnt[k]);
        end
      end
      tick();
      reset_n = 1'b1;
    end
  endtask

  task automatic test_random();
    int seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        seg = $urandom_range(1, 25);
        axis_block_sigs = 5'($urandom_range(0, 31));
        inst_block_sigs = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom_range(0, 31));
        inst_idle_sigs  = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 16383));
        enable          = ($urandom_range(0, 7) != 0);
      end
      seg--;
      clear = ($urandom_range(0, 39) == 0);
      tick();
      clear = 1'b0;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_block[k] !== m_block[k] || d_dl[k] !== m_dl[k] || d_ca[k] !== m_ca[k] ||
            d_cb[k] !== m_cb[k] || d_cnt[k] !== 8'(m_cnt[k])) begin
          errors++;
          $display("FAIL random k%0d cyc %0d got blk=%b dl=%b ca=%b cb=%b cnt=%0d expected blk=%b dl=%b ca=%b cb=%b cnt=%0d",
                   k, i, d_block[k], d_dl[k], d_ca[k], d_cb[k], d_cnt[k],
                   m_block[k], m_dl[k], m_ca[k], m_cb[k], m_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    p_th[0] = 16; p_am[0] = 5'b01100; p_bm[0] = 5'b00000; p_im[0] = 14'h0000; p_emax[0] = 255;
    p_th[1] = 16; p_am[1] = 5'b01100; p_bm[1] = 5'b00011; p_im[1] = 14'h3FFF; p_emax[1] = 3;
    p_th[2] = 1;  p_am[2] = 5'b01100; p_bm[2] = 5'b10000; p_im[2] = 14'h0000; p_emax[2] = 255;
    model_reset();
    test_reset();
    test_basic_window();
    test_restart();
    test_unmasked();
    test_idle();
    test_enable_clear();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hls_deadlock_persist_monitor.md
# hls_deadlock_persist_monitor

Parametrised per-process deadlock monitor for the HLS dataflow deadlock-detection network. It generalises the single-process monitor with configurable AXIS and instance-block widths and compile-time selection masks. It adds a persistence filter, so a block must hold for THRESHOLD consecutive cycles before it is declared a deadlock. It also adds a sticky deadlock flag with a captured cause snapshot, a software clear, and a saturating detection-event counter. One instance sits beside each monitored dataflow process and feeds the top-level deadlock aggregator.

## Interface
- NUM_AXIS, 5, width of axis_block_sigs
- NUM_BLK, 5, width of inst_block_sigs
- NUM_IDLE, 14, width of inst_idle_sigs
- AXIS_MASK, 5'b01100, selects which axis_block_sigs bits count toward a block
- BLK_MASK, 0, selects which inst_block_sigs bits count toward a block
- IDLE_MASK, 0, selects the idle bits used for suppression; 0 disables suppression
- THRESHOLD, 16, consecutive candidate cycles required to declare a deadlock; must be ≥1
- EVT_W, 8, width of detect_count
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- axis_block_sigs  in  NUM_AXIS  per-stream blocked indications
- inst_block_sigs  in  NUM_BLK  per-instance blocked indications
- inst_idle_sigs  in  NUM_IDLE  per-instance idle indications
- enable  in  1  monitoring enable; level-sensitive
- clear  in  1  synchronous clear of the sticky state; single-cycle pulse
- block  out  1  registered instantaneous block (candidate delayed one cycle)
- deadlock  out  1  sticky persistent-deadlock flag
- cause_axis  out  NUM_AXIS  masked axis_block_sigs captured on detection
- cause_blk  out  NUM_BLK  masked inst_block_sigs captured on detection
- detect_count  out  EVT_W  saturating count of IDLE/PENDING→DETECTED transitions

## Operation
- Suppression term: idle_all is high when IDLE_MASK≠0 and every IDLE_MASK bit of inst_idle_sigs is 1; otherwise idle_all is 0.
- Candidate: candidate = enable & ~idle_all & (|(axis_block_sigs & AXIS_MASK) | |(inst_block_sigs & BLK_MASK)).
- block register: block <= candidate every cycle, independent of state.
- Persistence counter cnt has width clog2(THRESHOLD+1).
- States are IDLE, PENDING and DETECTED. Encoding is free; deadlock is high exactly when the state is DETECTED.
- IDLE:
  - clear → IDLE.
  - candidate & THRESHOLD==1 → DETECTED.
  - candidate → PENDING with cnt=1.
  - otherwise stay in IDLE with cnt=0.
- PENDING:
  - clear or ~candidate → IDLE with cnt=0.
  - candidate & cnt==THRESHOLD-1 → DETECTED.
  - otherwise cnt+1.
- DETECTED:
  - Holds regardless of candidate or enable.
  - Only clear returns it to IDLE (cnt=0, cause_* = 0).
- On entry to DETECTED:
  - cause_axis <= axis_block_sigs & AXIS_MASK and cause_blk <= inst_block_sigs & BLK_MASK, both sampled in the transition cycle.
  - detect_count increments and saturates at all-ones.
- clear has priority over every transition, including a DETECTED entry in the same cycle. That entry is discarded and detect_count does not increment.
- clear does not affect block or detect_count.
- Deasserting enable forces candidate to 0, which aborts PENDING. It does not clear DETECTED.

## Timing
- Reset, asynchronous and active-low: block=0, deadlock=0, cause_axis=0, cause_blk=0, detect_count=0, cnt=0, state IDLE.
- Reset mid-PENDING or mid-DETECTED returns everything to reset values immediately; there is no partial state after release.
- block latency: 1 cycle from the inputs.
- deadlock latency:
  - Candidate continuously high in cycles t … t+THRESHOLD-1 → deadlock high from cycle t+THRESHOLD.
  - THRESHOLD=1 → deadlock rises in the same cycle as block.
- A single low-candidate cycle inside the window restarts counting from zero at the next high cycle.
- After clear in cycle c, deadlock=0 from c+1. If candidate stays high, re-detection needs a full new window starting at c+1.
- cause_* are stable while deadlock=1 and are 0 whenever deadlock=0.

## Test plan
- THRESHOLD=16, AXIS_MASK=5'b01100; hold axis_block_sigs=5'b00100 from cycle 10 → block=1 at cycle 11, deadlock=1 at cycle 26, cause_axis=5'b00100, detect_count=1.
- Same setup with the candidate dropped for one cycle at cycle 20, then held → no deadlock before cycle 37; deadlock=1 from cycle 37.
- axis_block_sigs=5'b10011 (all bits unmasked) held for 100 cycles → block and deadlock stay 0.
- IDLE_MASK=14'h3FFF with inst_idle_sigs all ones and a masked block asserted → block=0, deadlock=0. Drop one idle bit → deadlock=1 after 16 cycles.
- DETECTED, then enable=0 → deadlock stays 1. Pulse clear → deadlock=0 and cause_axis=0 next cycle, detect_count unchanged. Saturation check: EVT_W=2 with 5 detections → detect_count=3.
- Assert reset_n=0 asynchronously mid-PENDING and mid-DETECTED → all outputs 0 before the next clock edge. THRESHOLD=1 → deadlock and block rise together.
